// File: rtl/io_pin_conditioner_if.sv
// Conditioned pin outputs handed from io_pin_conditioner to user logic.
// The master side produces the debounced levels and pulses; the slave side consumes them.
interface io_pin_conditioner_if #(
  parameter int SIZE = 24
);
  logic [SIZE-1:0] level;
  logic [SIZE-1:0] rise;
  logic [SIZE-1:0] fall;
  logic            sample_strobe;

  modport master (
    output level,
    output rise,
    output fall,
    output sample_strobe
  );

  modport slave (
    input level,
    input rise,
    input fall,
    input sample_strobe
  );
endinterface

// File: rtl/io_pin_conditioner.sv
// Weak-pull emulation and per-channel debounce for undriven Io-board inputs (DIP switches, buttons).
// Pins are briefly driven to the idle level each period, then released and sampled once at period end.
module io_pin_conditioner #(
  parameter int SIZE             = 24,
  parameter int PULL_MODE        = 0,
  parameter int PULL_PERIOD      = 256,
  parameter int DISCHARGE_CYCLES = 4,
  parameter int DEBOUNCE_SAMPLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [SIZE-1:0]       pin,
  io_pin_conditioner_if.master  cond
);

  localparam int   PH_W     = (PULL_PERIOD > 1) ? $clog2(PULL_PERIOD) : 1;
  localparam int   CNT_W    = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES + 1) : 1;
  localparam logic IDLE_BIT = (PULL_MODE != 0);
  localparam logic [SIZE-1:0]  IDLE     = {SIZE{IDLE_BIT}};
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PULL_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_DIS   = PH_W'(DISCHARGE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic [PH_W-1:0]  ph;
  logic             drive_en;
  logic             is_sample;
  logic [SIZE-1:0]  sync1;
  logic [SIZE-1:0]  sync2;
  logic [SIZE-1:0]  level_q;
  logic [SIZE-1:0]  rise_q;
  logic [SIZE-1:0]  fall_q;
  logic [CNT_W-1:0] cnt [SIZE];

  // Pins are held at idle throughout reset so nothing floats before the phase counter runs.
  assign drive_en  = rst | (ph < PH_DIS);
  assign pin       = drive_en ? IDLE : {SIZE{1'bz}};
  assign is_sample = ~rst & (ph == PH_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= '0;
    end else if (ph == PH_LAST) begin
      ph <= '0;
    end else begin
      ph <= ph + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Only the last-cycle synchroniser output is used, so the discharge window never reaches the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= IDLE;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < SIZE; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      if (is_sample) begin
        for (int i = 0; i < SIZE; i++) begin
          if (sync2[i] == level_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            level_q[i] <= sync2[i];
            rise_q[i]  <= sync2[i];
            fall_q[i]  <= ~sync2[i];
            cnt[i]     <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign cond.level         = level_q;
  assign cond.rise          = rise_q;
  assign cond.fall          = fall_q;
  assign cond.sample_strobe = is_sample;

endmodule

// File: tb/tb_io_pin_conditioner.sv
// Directed bench for io_pin_conditioner: a pull-down and a pull-up instance with 16-cycle periods
// and 3-sample debounce, driven through weakly pulled tristate pins.
module tb_io_pin_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] oe_a, val_a, oe_b, val_b;
  wire  [7:0] pin_a;
  wire  [7:0] pin_b;
  int         n_checks = 0;
  int         n_fails  = 0;

  io_pin_conditioner_if #(.SIZE(8)) if_a ();
  io_pin_conditioner_if #(.SIZE(8)) if_b ();

  io_pin_conditioner #(
    .SIZE(8), .PULL_MODE(0), .PULL_PERIOD(16), .DISCHARGE_CYCLES(4), .DEBOUNCE_SAMPLES(3)
  ) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .pin  (pin_a),
    .cond (if_a.master)
  );

  io_pin_conditioner #(
    .SIZE(8), .PULL_MODE(1), .PULL_PERIOD(16), .DISCHARGE_CYCLES(4), .DEBOUNCE_SAMPLES(3)
  ) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .pin  (pin_b),
    .cond (if_b.master)
  );

  for (genvar i = 0; i < 8; i++) begin : g_pins
    pulldown (pin_a[i]);
    pullup   (pin_b[i]);
    assign pin_a[i] = oe_a[i] ? val_a[i] : 1'bz;
    assign pin_b[i] = oe_b[i] ? val_b[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to the cycle after the next sample cycle; n = cycles waited until the strobe (40 = timeout).
  task automatic next_sample(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!if_a.sample_strobe && n < 40);
    @(posedge clk); #1;
  endtask

  // From phase 1, the strobe appears 14 cycles later; pulses must be gone one cycle after they show.
  task automatic sample_a(input string tag, input logic [7:0] el, input logic [7:0] er,
                          input logic [7:0] ef);
    int n;
    next_sample(n);
    check({tag, "_gap"},  8'(n), 8'd14);
    check({tag, "_lvl"},  if_a.level, el);
    check({tag, "_rise"}, if_a.rise, er);
    check({tag, "_fall"}, if_a.fall, ef);
    @(posedge clk); #1;
    check({tag, "_rise_clr"}, if_a.rise, 8'h00);
    check({tag, "_fall_clr"}, if_a.fall, 8'h00);
  endtask

  task automatic sample_b(input string tag, input logic [7:0] el, input logic [7:0] er,
                          input logic [7:0] ef);
    int n;
    next_sample(n);
    check({tag, "_gap"},  8'(n), 8'd14);
    check({tag, "_lvl"},  if_b.level, el);
    check({tag, "_rise"}, if_b.rise, er);
    check({tag, "_fall"}, if_b.fall, ef);
    @(posedge clk); #1;
    check({tag, "_fall_clr"}, if_b.fall, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    oe_a  = 8'h00;
    val_a = 8'h00;
    oe_b  = 8'h00;
    val_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // Reset state of both instances
    check("rst_lvl_a",  if_a.level, 8'h00);
    check("rst_rise_a", if_a.rise, 8'h00);
    check("rst_fall_a", if_a.fall, 8'h00);
    check("rst_strb_a", {7'd0, if_a.sample_strobe}, 8'h00);
    check("rst_pin_a",  pin_a, 8'h00);
    check("rst_lvl_b",  if_b.level, 8'hFF);
    check("rst_pin_b",  pin_b, 8'hFF);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle pins: no activity, regular strobes
    sample_a("t1_s1", 8'h00, 8'h00, 8'h00);
    sample_a("t1_s2", 8'h00, 8'h00, 8'h00);

    // pin[5] held high: rise after the third sample
    oe_a = 8'h20; val_a = 8'h20;
    sample_a("t2_s1", 8'h00, 8'h00, 8'h00);
    sample_a("t2_s2", 8'h00, 8'h00, 8'h00);
    sample_a("t2_s3", 8'h20, 8'h20, 8'h00);

    // pin[2] bounces 1,1,0,1,1,1
    oe_a = 8'h24; val_a = 8'h24;
    sample_a("t3_s1", 8'h20, 8'h00, 8'h00);
    sample_a("t3_s2", 8'h20, 8'h00, 8'h00);
    val_a = 8'h20;
    sample_a("t3_s3", 8'h20, 8'h00, 8'h00);
    val_a = 8'h24;
    sample_a("t3_s4", 8'h20, 8'h00, 8'h00);
    sample_a("t3_s5", 8'h20, 8'h00, 8'h00);
    sample_a("t3_s6", 8'h24, 8'h04, 8'h00);

    // pin[0] and pin[7] rise together, then are released together
    oe_a = 8'hA5; val_a = 8'hA5;
    sample_a("t4_r1", 8'h24, 8'h00, 8'h00);
    sample_a("t4_r2", 8'h24, 8'h00, 8'h00);
    sample_a("t4_r3", 8'hA5, 8'h81, 8'h00);
    oe_a = 8'h24; val_a = 8'h24;
    sample_a("t4_f1", 8'hA5, 8'h00, 8'h00);
    sample_a("t4_f2", 8'hA5, 8'h00, 8'h00);
    sample_a("t4_f3", 8'h24, 8'h00, 8'h81);
    oe_a = 8'h00; val_a = 8'h00;
    sample_a("t4_g1", 8'h24, 8'h00, 8'h00);
    sample_a("t4_g2", 8'h24, 8'h00, 8'h00);
    sample_a("t4_g3", 8'h00, 8'h00, 8'h24);

    // Reset in the middle of a debounce on pin[3]
    oe_a = 8'h08; val_a = 8'h08;
    sample_a("t5_p1", 8'h00, 8'h00, 8'h00);
    sample_a("t5_p2", 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_lvl",  if_a.level, 8'h00);
    check("t5_rst_rise", if_a.rise, 8'h00);
    check("t5_rst_strb", {7'd0, if_a.sample_strobe}, 8'h00);
    check("t5_rst_lvlb", if_b.level, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    sample_a("t5_s1", 8'h00, 8'h00, 8'h00);
    sample_a("t5_s2", 8'h00, 8'h00, 8'h00);
    sample_a("t5_s3", 8'h08, 8'h08, 8'h00);

    // Pull-up instance: pin[4] held low gives a fall after three samples
    oe_b = 8'h10; val_b = 8'h00;
    sample_b("t6_s1", 8'hFF, 8'h00, 8'h00);
    sample_b("t6_s2", 8'hFF, 8'h00, 8'h00);
    sample_b("t6_s3", 8'hEF, 8'h00, 8'h10);
    check("t6_lvl_a", if_a.level, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
